cp0_unit: RTL

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline, sitting alongside the M stage. It holds SR, Cause, EPC and PRId, evaluates the M-stage exception code and the external hardware interrupt lines every cycle, and raises `Req`. Every pipeline register samples `Req` to flush itself and redirect to the handler at 0x00004180. It also services `mfc0`, `mtc0` and `eret` issued from M.

---
 rtl/cp0_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller for the M stage: SR, Cause, EPC, PRId,
// flush request generation and mfc0/mtc0/eret servicing.
module cp0_unit #(
    parameter logic [31:0] PRID    = 32'h20240000,
    parameter logic [31:0] HANDLER = 32'h00004180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        WE,
    input  logic [31:0] M_pc,
    input  logic [4:0]  M_ExcCode,
    input  logic        M_BD,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic        Req,
    output logic [31:0] ExcEntry,
    output logic [31:0] Dout,
    output logic [31:0] EPCout
);
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Only the implemented fields are stored; all other bits are constant zero.
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic int_req;
    logic exc_req;

    assign int_req  = ie & ~exl & (|(HWInt & im));
    assign exc_req  = ~exl & (M_ExcCode != 5'd0);
    assign Req      = reset & (int_req | exc_req);
    assign ExcEntry = HANDLER;
    assign EPCout   = epc;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : M_ExcCode;
                bd       <= M_BD;
                epc      <= M_BD ? (M_pc - 32'd4) : M_pc;
            end else begin
                if (WE && A2 == REG_SR) begin
                    im  <= Din[15:10];
                    exl <= Din[1];
                    ie  <= Din[0];
                end
                if (WE && A2 == REG_EPC) begin
                    epc <= Din;
                end
                // Placed after the SR write so eret overrides the EXL bit of Din.
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves Dout
        // unassigned, which would otherwise infer a latch.
        Dout = '0;
        case (A1)
            REG_SR:    Dout = {16'b0, im, 8'b0, exl, ie};
            REG_CAUSE: Dout = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
            REG_EPC:   Dout = epc;
            REG_PRID:  Dout = PRID;
            default:   Dout = '0;
        endcase
    end
endmodule
